fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch unit between the program counter and instruction memory.
- Accepts one address at a time from the PC over a valid/ready handshake and issues a single-outstanding read to instruction memory over a req/ack handshake.
- Buffers returned words with their addresses in a small FIFO for the decoder.
- Flush discards buffered and in-flight fetches on jump, call or return.

Parameters:
- AW, 32, address width.
- DW, 32, instruction word width.
- DEPTH, 2, prefetch FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- pc_addr  input  AW  address of the next instruction from the PC.
- pc_valid  input  1  pc_addr is valid.
- pc_ready  output  1  fetch unit accepts pc_addr this cycle.
- flush  input  1  discard all buffered and in-flight fetches (redirect).
- mem_req  output  1  read request to instruction memory.
- mem_addr  output  AW  read address; stable while mem_req=1.
- mem_ack  input  1  read complete; mem_rdata valid this cycle.
- mem_rdata  input  DW  read data.
- instr_valid  output  1  FIFO head valid.
- instr_ready  input  1  decoder consumes head.
- instr  output  DW  head instruction word.
- instr_pc  output  AW  head instruction address.
- instr_fault  output  1  head entry is a misaligned-address fault; tied 0 without the macro.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, count=0, FIFO pointers=0, kill=0.
  - mem_req=0, mem_addr=0, instr=0, instr_pc=0, instr_valid=0.
  - Reset overrides flush and all handshakes, including mid-request.
- States: IDLE, REQ.
  - IDLE: pc_ready = (count<DEPTH) && !flush. On pc_valid&&pc_ready, latch pc_addr into mem_addr, clear kill, go to REQ.
  - REQ: mem_req=1, mem_addr held. On mem_ack, push {mem_addr, mem_rdata} unless kill=1, then go to IDLE. mem_ack outside REQ is ignored.
- Latency: PC accept at cycle N, mem_req at N+1. Ack at N+1 gives instr_valid at N+2 (minimum 2 cycles).
- Throughput: one fetch per 2 cycles at best; pc_ready=0 throughout REQ.
- FIFO:
  - instr_valid = count!=0; pop on instr_valid&&instr_ready.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow cannot occur because accepts require count<DEPTH with no request in flight.
- Flush:
  - count and pointers go to 0 at the next edge; any same-cycle pop and push are dropped.
  - In REQ: mem_req stays asserted (requests are never retracted), kill is set, and the returning data is discarded.
  - A flush in the same cycle as a mem_ack drops that data.
  - pc_ready=0 during the flush cycle.
- Priority: rst > flush > push/pop.

Optional Feature:
- FETCH_ALIGN_CHECK_EN defined:
  - In IDLE, an accepted pc_addr[1:0]!=0 issues no memory request.
  - Instead a fault entry is pushed next cycle: instr=0, instr_pc=pc_addr, instr_fault=1.
  - State stays IDLE; the entry is flushable like any other.
- Undefined: mem_addr[1:0] is forced to 2'b00, no fault entries exist, and instr_fault=0.

Decomposition:
- Package fetch_pkg: state encodings FETCH_IDLE and FETCH_REQ; FETCH_NOP=32'h0 fault/filler word; entry width constant AW+DW+1.
- Sub-module fetch_fifo:
  - Parameters DEPTH and WIDTH.
  - Ports: push, pop, clear, full, empty, count, din, dout.
  - Synchronous clear has priority over push and pop.

Test Plan:
- Reset then pc_addr=0x0 valid, mem_ack 1 cycle after mem_req with data 0x8C010004 -> instr_valid at cycle 2, instr=0x8C010004, instr_pc=0x0.
- Addresses 0x0, 0x4, 0x8 with instr_ready=0, DEPTH=2 -> two entries buffered, pc_ready=0. Pop one -> 0x8 accepted; order 0x0, 0x4, 0x8 preserved.
- flush in REQ for addr 0x10, ack 3 cycles later with 0xDEAD -> mem_req held until ack, 0xDEAD not pushed, instr_valid=0.
- flush with 2 buffered entries plus simultaneous instr_ready -> count=0 next cycle, next fetch 0x40 is the only entry delivered.
- rst asserted during REQ -> mem_req=0 next cycle, all outputs 0, subsequent fetch of 0x0 works.
- FETCH_ALIGN_CHECK_EN with pc_addr=0x6 -> no mem_req, entry instr_pc=0x6, instr_fault=1. Without the macro -> mem_addr=0x4, instr_fault=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, filler word, entry width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  // Two-state fetch controller: waiting for a PC address, or one read outstanding.
  typedef enum logic [0:0] {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_t;

  // Word delivered in fault entries; also a harmless filler encoding.
  localparam logic [31:0] FETCH_NOP = 32'h0000_0000;

  // Default widths and the resulting FIFO entry width {fault, pc, word}.
  localparam int FETCH_AW      = 32;
  localparam int FETCH_DW      = 32;
  localparam int FETCH_ENTRY_W = FETCH_AW + FETCH_DW + 1;

  // Entry width for non-default address/data widths.
  function automatic int fetch_entry_w(input int aw, input int dw);
    return aw + dw + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched entries for the decoder.
// Latency: a push is visible at dout/empty the cycle after the push edge.
// Backpressure: none internally; the caller never pushes when full nor pops when empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    cnt;

  // Pointer and occupancy update; clear beats push/pop, pointers wrap at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push && !clear && !rst) begin
      store[wptr] <= din;
    end
  end

  assign dout  = store[rptr];
  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: takes PC addresses, issues single-outstanding memory reads, buffers {pc, word} for decode.
// Latency: PC accept at N, mem_req at N+1, ack at N+1 gives instr_valid at N+2 (2 cycles minimum).
// Backpressure: pc_ready low while a read is in flight, the FIFO has no room, or flush is high.
// Optional: define FETCH_ALIGN_CHECK_EN to turn misaligned PC addresses into fault entries instead of reads.
module fetch_unit #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_addr,
  input  logic          pc_valid,
  output logic          pc_ready,
  input  logic          flush,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_fault
);

  import fetch_pkg::*;

  localparam int EW = fetch_entry_w(AW, DW);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [AW-1:0]   mem_addr_q;
  logic            kill;
  logic            issue;
  logic            mem_push;
  logic            room;

  logic            fifo_push;
  logic            fifo_pop;
  logic [EW-1:0]   fifo_din;
  logic [EW-1:0]   fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);

  logic            fault_take;
  logic            fault_pend;
  logic [AW-1:0]   fault_pc;
`endif

  // A pending fault entry has not reached the FIFO count yet, so it must reserve a slot.
`ifdef FETCH_ALIGN_CHECK_EN
  assign room = fault_pend ? (fifo_count < LAST_SLOT) : !fifo_full;
`else
  assign room = !fifo_full;
`endif

  assign pc_ready = (state == FETCH_IDLE) && room && !flush;

  // Next-state and push decode; a killed read still completes its handshake but is not buffered.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    mem_push  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_take = 1'b0;
`endif
    case (state)
      FETCH_IDLE: begin
        if (pc_valid && pc_ready) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (pc_addr[1:0] != 2'b00) begin
            fault_take = 1'b1;
          end else begin
            issue     = 1'b1;
            state_nxt = FETCH_REQ;
          end
`else
          issue     = 1'b1;
          state_nxt = FETCH_REQ;
`endif
        end
      end
      FETCH_REQ: begin
        if (mem_ack) begin
          mem_push  = !kill;
          state_nxt = FETCH_IDLE;
        end
      end
      default: begin
        state_nxt = FETCH_IDLE;
      end
    endcase
  end

  // State, held read address and kill flag; a flush during a read lets it finish but marks it stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH_IDLE;
      mem_addr_q <= '0;
      kill       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        mem_addr_q <= {pc_addr[AW-1:2], 2'b00};
        kill       <= 1'b0;
      end else if ((state == FETCH_REQ) && flush) begin
        kill <= 1'b1;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Misaligned accept becomes a fault entry written on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_pend <= 1'b0;
      fault_pc   <= '0;
    end else begin
      fault_pend <= fault_take;
      if (fault_take) begin
        fault_pc <= pc_addr;
      end
    end
  end

  // Fault entries only occur while idle, so they never collide with a memory return.
  assign fifo_push = mem_push | fault_pend;
  assign fifo_din  = fault_pend ? {1'b1, fault_pc, DW'(FETCH_NOP)}
                                : {1'b0, mem_addr_q, mem_rdata};
`else
  assign fifo_push = mem_push;
  assign fifo_din  = {1'b0, mem_addr_q, mem_rdata};

  logic unused_noalign;
  assign unused_noalign = ^{pc_addr[1:0], fifo_count, fifo_dout[EW-1]};
`endif

  assign fifo_pop = instr_valid && instr_ready;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign mem_req  = (state == FETCH_REQ);
  assign mem_addr = mem_addr_q;

  // Head fields read as zero when nothing is buffered, so reset shows clean outputs.
  assign instr_valid = !fifo_empty;
  assign instr       = instr_valid ? fifo_dout[DW-1:0]  : '0;
  assign instr_pc    = instr_valid ? fifo_dout[DW +: AW] : '0;
`ifdef FETCH_ALIGN_CHECK_EN
  assign instr_fault = instr_valid && fifo_dout[EW-1];
`else
  assign instr_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized traffic, checked by a queue-based reference.
// Latency: n/a.
// Backpressure: the bench drives instr_ready and mem_ack delays randomly.
module tb_fetch_unit;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc_addr = '0;
  logic          pc_valid = 1'b0;
  logic          pc_ready;
  logic          flush = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_fault;

  always #5 clk = ~clk;

  fetch_unit #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_addr     (pc_addr),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_fault (instr_fault)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0)  return 32'h8C01_0004;
    if (a == 32'h10) return 32'h0000_DEAD;
    return (a * 32'h9E37_79B1) + 32'h0123_4567;
  endfunction

  // ---------------- memory responder ----------------
  bit ack_rand  = 1'b0;
  bit stray_en  = 1'b0;
  int ack_fix   = 0;
  int ack_delay = 0;
  int wait_cnt  = 0;

  always @(posedge clk) begin
    #1;
    if (rst || !mem_req || mem_ack) begin
      wait_cnt  = 0;
      ack_delay = ack_rand ? int'($urandom_range(0, 3)) : ack_fix;
      if (!rst && !mem_req && stray_en && ($urandom_range(0, 7) == 0)) begin
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
      end else begin
        mem_ack = 1'b0;
      end
    end else if (wait_cnt >= ack_delay) begin
      mem_ack   = 1'b1;
      mem_rdata = memfn(mem_addr);
    end else begin
      wait_cnt++;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        fault;
  } ent_t;

  ent_t        q[$];
  bit          inflight = 1'b0;
  bit          killed   = 1'b0;
  logic [31:0] exp_addr = '0;
  bit          pend     = 1'b0;
  logic [31:0] pend_pc  = '0;

  // Before each edge: check visible outputs against model state, then apply what the edge will do.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      inflight = 1'b0;
      killed   = 1'b0;
      pend     = 1'b0;
    end else begin
      bit exp_rdy;
      exp_rdy = !inflight && !flush && ((q.size() + int'(pend)) < DEPTH);
      check("pc_ready", pc_ready, exp_rdy);
      check("instr_valid", instr_valid, q.size() != 0);
      check("mem_req", mem_req, inflight);
      if (inflight) check("mem_addr", mem_addr, exp_addr);
      if (pend && !flush) q.push_back('{pend_pc, 32'h0, 1'b1});
      pend = 1'b0;
      if (flush) begin
        q.delete();
        if (inflight) killed = 1'b1;
      end
      if (inflight && mem_ack) begin
        if (!killed) q.push_back('{exp_addr, memfn(exp_addr), 1'b0});
        inflight = 1'b0;
      end
      if (pc_valid && exp_rdy) begin
`ifdef FETCH_ALIGN_CHECK_EN
        if (pc_addr[1:0] != 2'b00) begin
          pend    = 1'b1;
          pend_pc = pc_addr;
        end else begin
          inflight = 1'b1;
          killed   = 1'b0;
          exp_addr = {pc_addr[31:2], 2'b00};
        end
`else
        inflight = 1'b1;
        killed   = 1'b0;
        exp_addr = {pc_addr[31:2], 2'b00};
`endif
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    #1;
    if (!rst && !flush && instr_valid && instr_ready) begin
      if (q.size() == 0) begin
        check("pop_unexpected", instr_valid, 1'b0);
      end else begin
        ent_t e;
        e = q.pop_front();
        check("instr", instr, e.word);
        check("instr_pc", instr_pc, e.pc);
        check("instr_fault", instr_fault, e.fault);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    int t;
    pc_addr  = a;
    pc_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!pc_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("fetch_accept_timeout", t >= 100, 1'b0);
    @(posedge clk);
    #1;
    pc_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    rst = 1'b0;
    // reset state
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_pc_ready", pc_ready, 1'b1);

    // first fetch: minimum latency
    fetch(32'h0);
    check("lat_n1_valid", instr_valid, 1'b0);
    check("lat_n1_req", mem_req, 1'b1);
    step(1);
    check("lat_n2_valid", instr_valid, 1'b1);
    check("lat_n2_instr", instr, 32'h8C01_0004);
    check("lat_n2_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;

    // fill the FIFO, third fetch waits for a pop
    fetch(32'h0);
    fetch(32'h4);
    fork
      fetch(32'h8);
      begin
        step(4);
        check("full_pc_ready", pc_ready, 1'b0);
        check("full_valid", instr_valid, 1'b1);
        instr_ready = 1'b1;
        step(1);
        instr_ready = 1'b0;
      end
    join
    instr_ready = 1'b1;
    step(6);
    check("fill_drained", instr_valid, 1'b0);
    instr_ready = 1'b0;

    // flush while a read is outstanding; late data must be dropped
    ack_fix = 3;
    fetch(32'h10);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("kill_req_held", mem_req, 1'b1);
    step(6);
    check("kill_no_entry", instr_valid, 1'b0);

    // flush with two buffered entries and a simultaneous pop
    ack_fix = 0;
    fetch(32'h20);
    fetch(32'h24);
    step(3);
    flush = 1'b1;
    instr_ready = 1'b1;
    step(1);
    flush = 1'b0;
    instr_ready = 1'b0;
    check("flush_empty", instr_valid, 1'b0);
    fetch(32'h40);
    instr_ready = 1'b1;
    step(4);
    check("flush_only_one", instr_valid, 1'b0);
    instr_ready = 1'b0;

    // reset in the middle of a request
    ack_fix = 3;
    fetch(32'h30);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    check("midrst_valid", instr_valid, 1'b0);
    check("midrst_pc_ready", pc_ready, 1'b1);
    ack_fix = 0;
    fetch(32'h0);
    step(2);
    instr_ready = 1'b1;
    step(2);
    instr_ready = 1'b0;

    // misaligned address
    fetch(32'h6);
`ifdef FETCH_ALIGN_CHECK_EN
    check("misalign_no_req", mem_req, 1'b0);
`else
    check("misalign_mem_addr", mem_addr, 32'h4);
`endif
    step(2);
    instr_ready = 1'b1;
    step(2);
    instr_ready = 1'b0;

    // randomized traffic
    ack_rand = 1'b1;
    stray_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      pc_valid    = ($urandom_range(0, 9) < 6);
      pc_addr     = ($urandom & 32'h0000_0FFC) |
                    (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      instr_ready = $urandom_range(0, 1) != 0;
      flush       = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      step(1);
    end

    // drain
    stray_en    = 1'b0;
    pc_valid    = 1'b0;
    flush       = 1'b0;
    rst         = 1'b0;
    instr_ready = 1'b1;
    step(20);
    check("drain_queue", q.size(), 0);
    check("drain_valid", instr_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
